// File: rtl/vga_vram_arbiter.sv
// ---------------------------------------------------------------------------
// vga_vram_arbiter
//
// Shares one single-port 32-bit VRAM between the VGA scan-out fetch path and
// the CPU bus. The display wins contention unless the CPU has been pending and
// denied for STARVE_LIMIT cycles. Every access has a fixed one-cycle latency,
// and read data is routed back to whichever requester issued it.
//
// Owner register:
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   OWN_NONE    | no access was issued last cycle; no response this cycle
//   OWN_DISP    | display read issued last cycle; ram_rdata goes to display
//   OWN_CPU_RD  | CPU read issued last cycle; ram_rdata goes to CPU
//   OWN_CPU_WR  | CPU write issued last cycle; CPU gets a zero-data ack
//
// Ports:
//   clk, resetn                      clock, async active-low reset
//   disp_req/addr -> disp_gnt        display request/grant
//   disp_rvalid/rdata                display response (bit 31 = leftmost px)
//   cpu_req/we/wstrb/addr/wdata      CPU request fields, cpu_gnt grant
//   cpu_rvalid/rdata                 CPU response (read data or write ack)
//   ram_en/we/addr/wdata, ram_rdata  VRAM macro port (1-cycle read latency)
// ---------------------------------------------------------------------------
module vga_vram_arbiter #(
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [31:0]       disp_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_wstrb,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_DISP   = 2'd1,
        OWN_CPU_RD = 2'd2,
        OWN_CPU_WR = 2'd3
    } owner_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    owner_t      owner_q, owner_d;
    logic [7:0]  starve_cnt_q, starve_cnt_d;
    logic [31:0] disp_rdata_q, disp_rdata_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic        cpu_win;
    logic        disp_win;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q      <= OWN_NONE;
            starve_cnt_q <= 8'd0;
            disp_rdata_q <= 32'd0;
            cpu_rdata_q  <= 32'd0;
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            disp_rdata_q <= disp_rdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

    always_comb begin
        cpu_win      = 1'b0;
        disp_win     = 1'b0;
        owner_d      = OWN_NONE;
        starve_cnt_d = starve_cnt_q;

        // Grants are gated while reset is held so that an access granted just
        // before reset asserts is never issued to the RAM or answered later.
        if (resetn) begin
            // Registered count: the CPU wins on the cycle the limit is reached.
            if (cpu_req && (!disp_req || (starve_cnt_q >= LIMIT))) begin
                cpu_win = 1'b1;
            end else if (disp_req) begin
                disp_win = 1'b1;
            end
        end

        if (cpu_win) begin
            owner_d      = cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
            starve_cnt_d = 8'd0;
        end else begin
            if (disp_win) begin
                owner_d = OWN_DISP;
            end
            if (cpu_req && resetn && (starve_cnt_q != 8'hFF)) begin
                starve_cnt_d = starve_cnt_q + 8'd1;
            end
        end
    end

    assign disp_gnt  = disp_win;
    assign cpu_gnt   = cpu_win;
    assign ram_en    = disp_win | cpu_win;
    assign ram_addr  = cpu_win ? cpu_addr : disp_addr;
    assign ram_we    = (cpu_win && cpu_we) ? cpu_wstrb : 4'b0000;
    assign ram_wdata = cpu_wdata;

    // Response side: data is passed straight through from the RAM in the
    // response cycle and captured so it holds while rvalid is low.
    always_comb begin
        disp_rvalid  = 1'b0;
        cpu_rvalid   = 1'b0;
        disp_rdata_d = disp_rdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        unique case (owner_q)
            OWN_DISP: begin
                disp_rvalid  = 1'b1;
                disp_rdata_d = ram_rdata;
            end
            OWN_CPU_RD: begin
                cpu_rvalid  = 1'b1;
                cpu_rdata_d = ram_rdata;
            end
            OWN_CPU_WR: begin
                cpu_rvalid  = 1'b1;
                cpu_rdata_d = 32'd0;
            end
            default: ;
        endcase
    end

    assign disp_rdata = disp_rdata_d;
    assign cpu_rdata  = cpu_rdata_d;

endmodule

// File: doc/vga_vram_arbiter.md
Name: vga_vram_arbiter

Overview:
- Shares one single-port 32-bit video memory (1 bpp, 20 words per 640-pixel line) between two requesters: the VGA scan-out fetch path and the CPU bus.
- Display reads take priority; a starvation counter guarantees CPU forward progress.
- Sits between the VGA pixel/data path, the CPU peripheral bus bridge and the VRAM macro.
- Sequences every VRAM cycle and routes read data back to the requester that issued it.

Parameters:
- ADDR_W, 14, word-address width of the VRAM.
- STARVE_LIMIT, 8, number of consecutive cycles the CPU may be pending and denied before it wins the next contention; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- disp_req  in  1  display read request; held until granted.
- disp_addr  in  ADDR_W  display word address.
- disp_gnt  out  1  display request accepted this cycle.
- disp_rvalid  out  1  display read data valid.
- disp_rdata  out  32  display read data; bit 31 is the leftmost pixel.
- cpu_req  in  1  CPU request; held with stable fields until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_wstrb  in  4  byte enables for writes.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  32  CPU write data.
- cpu_gnt  out  1  CPU request accepted this cycle.
- cpu_rvalid  out  1  CPU completion (read data or write ack).
- cpu_rdata  out  32  CPU read data.
- ram_en  out  1  VRAM access enable.
- ram_we  out  4  VRAM byte write enables.
- ram_addr  out  ADDR_W  VRAM address.
- ram_wdata  out  32  VRAM write data.
- ram_rdata  in  32  VRAM read data; valid one cycle after a read with ram_en=1.

Behaviour:
- Reset (resetn low, asynchronous):
  - Clears the starvation counter and the owner register.
  - Forces disp_rvalid=0, cpu_rvalid=0, disp_rdata=0, cpu_rdata=0.
  - Combinational outputs with all requests low: ram_en=0, ram_we=0, gnt=0.
- Arbitration (combinational, evaluated every cycle):
  - Only disp_req: display granted.
  - Only cpu_req: CPU granted.
  - Both: CPU granted iff starve_cnt >= STARVE_LIMIT; otherwise display.
- Exactly one requester is granted per cycle.
  - The granted requester's gnt=1 and ram_en=1.
  - ram_addr comes from the winner.
  - ram_we = cpu_wstrb only for a CPU write, else 0.
  - ram_wdata = cpu_wdata.
- Handshake: a transfer occurs on a cycle with req=1 and gnt=1. The requester may change fields or drop req after that edge. Requesters must not drop req before grant; behaviour if they do is unspecified for the verifier.
- Owner register (states NONE, DISP, CPU_RD, CPU_WR):
  - Loaded at each edge with the type of the access granted that cycle (NONE if no access).
  - The next cycle, it drives the response for that access.
- Response, one cycle after grant:
  - owner=DISP: disp_rvalid=1, disp_rdata=ram_rdata.
  - owner=CPU_RD: cpu_rvalid=1, cpu_rdata=ram_rdata.
  - owner=CPU_WR: cpu_rvalid=1, cpu_rdata=0.
  - rdata registers hold their value when the matching rvalid is 0.
- Fixed latency and throughput: back-to-back grants are legal, giving one access per cycle. Latency from grant to rvalid is exactly 1 cycle.
- Starvation counter (8-bit):
  - Increments on each cycle with cpu_req=1 and cpu_gnt=0.
  - Saturates at 255.
  - Clears to 0 on any cycle with cpu_gnt=1.
  - Unchanged when cpu_req=0.
- Boundary conditions:
  - Both requests arriving in the same cycle as starve_cnt reaching the limit: CPU wins that cycle, because the comparison uses the registered count.
  - Display starved by the CPU: for at most 1 cycle per STARVE_LIMIT+1 cycles.
  - Addresses wrap naturally modulo 2^ADDR_W.
  - Reset asserted mid-access: the pending response is dropped (no rvalid after reset release).

Test Plan:
- Reset: hold resetn=0 with both requests high -> all gnt, rvalid, ram_en=0; rdata=0.
- Lone display read: disp_req=1, addr=0x0014, ram_rdata=0xF0F0_0000 next cycle -> disp_gnt=1, ram_addr=0x0014 in cycle 0; disp_rvalid=1, disp_rdata=0xF0F0_0000 in cycle 1; cpu_rvalid=0.
- CPU byte write: cpu_req=1, we=1, wstrb=4'b0010, addr=0x0100, wdata=0x0000_AB00 -> ram_we=4'b0010, ram_addr=0x0100, cpu_gnt=1; cpu_rvalid=1, cpu_rdata=0 next cycle.
- Contention, STARVE_LIMIT=8: disp_req held high, cpu_req read held high -> display granted cycles 0-7; CPU granted cycle 8; display granted cycles 9-16; CPU granted cycle 17.
- Back-to-back: alternate disp read (0x0000) and CPU read (0x0001) each cycle with single requesters -> every cycle ram_en=1; responses are routed to the correct rvalid with no gaps or cross-routing.
- Reset mid-access: grant a CPU read, then assert resetn=0 before the next edge, then release -> cpu_rvalid never asserts; starve_cnt=0 after release.
